vga_timing_gen: RTL and testbench

//  Parametrised VGA raster timing generator with a built-in pixel-rate prescaler.

---
 rtl/vga_timing_gen.sv | 114 +++++++++++
 tb/tb_vga_timing_gen.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator with a pixel-rate prescaler.
// Ports: clk/rst/en in; pix_ce, hsync, vsync, active, x, y, line_start, frame_start out.
module vga_timing_gen #(
  parameter int   PIX_DIV  = 2,
  parameter int   H_ACTIVE = 640,
  parameter int   H_FP     = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter logic H_POL    = 1'b0,
  parameter logic V_POL    = 1'b0,
  localparam int  H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int  V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int  XW       = $clog2(H_TOTAL),
  localparam int  YW       = $clog2(V_TOTAL)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  output logic          pix_ce,
  output logic          hsync,
  output logic          vsync,
  output logic          active,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic          line_start,
  output logic          frame_start
);

  generate
    if (PIX_DIV < 1 || H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 ||
        H_BP < 1 || V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 ||
        V_BP < 1) begin : g_bad_param
      $error("vga_timing_gen: PIX_DIV and timing values must be >= 1");
    end
  endgenerate

  localparam int DW = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(PIX_DIV - 1);

  localparam logic [XW-1:0] H_LAST = XW'(H_TOTAL - 1);
  localparam logic [XW-1:0] H_ACT  = XW'(H_ACTIVE);
  localparam logic [XW-1:0] HS_BEG = XW'(H_ACTIVE + H_FP);
  localparam logic [XW-1:0] HS_END = XW'(H_ACTIVE + H_FP + H_SYNC);

  localparam logic [YW-1:0] V_LAST = YW'(V_TOTAL - 1);
  localparam logic [YW-1:0] V_ACT  = YW'(V_ACTIVE);
  localparam logic [YW-1:0] VS_BEG = YW'(V_ACTIVE + V_FP);
  localparam logic [YW-1:0] VS_END = YW'(V_ACTIVE + V_FP + V_SYNC);

  logic [DW-1:0] div_cnt;
  logic [XW-1:0] h;
  logic [YW-1:0] v;

  logic          tick;
  logic [XW-1:0] h_nxt;
  logic [YW-1:0] v_nxt;
  logic          act_nxt;
  logic          hs_nxt;
  logic          vs_nxt;

  assign tick = en && (div_cnt == DIV_LAST);

  // Outputs are derived from the next position so they
  // line up with pix_ce on the same edge.
  always_comb begin
    h_nxt = h + XW'(1);
    v_nxt = v;
    if (h == H_LAST) begin
      h_nxt = '0;
      v_nxt = (v == V_LAST) ? '0 : v + YW'(1);
    end
    act_nxt = (h_nxt < H_ACT) && (v_nxt < V_ACT);
    hs_nxt  = (h_nxt >= HS_BEG) && (h_nxt < HS_END);
    vs_nxt  = (v_nxt >= VS_BEG) && (v_nxt < VS_END);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt     <= '0;
      h           <= H_LAST;
      v           <= V_LAST;
      pix_ce      <= 1'b0;
      hsync       <= ~H_POL;
      vsync       <= ~V_POL;
      active      <= 1'b0;
      x           <= '0;
      y           <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      pix_ce      <= tick;
      line_start  <= tick && (h_nxt == '0);
      frame_start <= tick && (h_nxt == '0) && (v_nxt == '0);
      if (en) begin
        div_cnt <= tick ? '0 : div_cnt + DW'(1);
      end
      if (tick) begin
        h      <= h_nxt;
        v      <= v_nxt;
        hsync  <= hs_nxt ? H_POL : ~H_POL;
        vsync  <= vs_nxt ? V_POL : ~V_POL;
        active <= act_nxt;
        x      <= act_nxt ? h_nxt : '0;
        y      <= act_nxt ? v_nxt : '0;
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default mode and a tiny fast mode,
// checked each cycle against a position-from-pixel-count model.
module tb_vga_timing_gen;

  localparam int PDB = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a = 1'b1, en_a = 1'b0;
  logic rst_b = 1'b1, en_b = 1'b0;

  logic       ce_a, hs_a, vs_a, act_a, ls_a, fs_a;
  logic [9:0] x_a, y_a;
  logic       ce_b, hs_b, vs_b, act_b, ls_b, fs_b;
  logic [2:0] x_b, y_b;

  vga_timing_gen u_a (
    .clk(clk), .rst(rst_a), .en(en_a),
    .pix_ce(ce_a), .hsync(hs_a), .vsync(vs_a), .active(act_a),
    .x(x_a), .y(y_a), .line_start(ls_a), .frame_start(fs_a)
  );

  vga_timing_gen #(
    .PIX_DIV(PDB),
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .H_POL(1'b1), .V_POL(1'b0)
  ) u_b (
    .clk(clk), .rst(rst_b), .en(en_b),
    .pix_ce(ce_b), .hsync(hs_b), .vsync(vs_b), .active(act_b),
    .x(x_b), .y(y_b), .line_start(ls_b), .frame_start(fs_b)
  );

  int total = 0;
  int bad   = 0;
  bit chk_on = 1'b0;

  // Model state: enabled clocks since reset, and whether
  // the last edge produced a pixel strobe.
  longint na = 0, nb = 0;
  bit     cea = 1'b0, ceb = 1'b0;

  task automatic chk(input string nm, input longint act,
                     input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d at %0t", nm, act, exp,
               $time);
    end
  endtask

  // Pixel k (1-based tick count) sits at raster index k-1;
  // before any tick the position is the last pixel of the frame.
  task automatic model(
    input int pd, input int ha, input int hf, input int hs,
    input int hb, input int va, input int vf, input int vs,
    input int vb, input bit hp, input bit vp,
    input longint n, input bit ce,
    output logic [5:0] o, output longint xo, output longint yo);
    longint ht, vt, k, lin, h, v;
    bit a;
    ht  = ha + hf + hs + hb;
    vt  = va + vf + vs + vb;
    k   = n / pd;
    lin = (k + ht * vt - 1) % (ht * vt);
    h   = lin % ht;
    v   = lin / ht;
    a   = (h < ha) && (v < va);
    o[5] = ce;
    o[4] = (h >= ha + hf && h < ha + hf + hs) ? hp : !hp;
    o[3] = (v >= va + vf && v < va + vf + vs) ? vp : !vp;
    o[2] = a;
    o[1] = ce && h == 0;
    o[0] = ce && h == 0 && v == 0;
    xo = a ? h : 0;
    yo = a ? v : 0;
  endtask

  always @(posedge clk) begin
    if (rst_a) begin
      na = 0; cea = 1'b0;
    end else if (en_a) begin
      cea = ((na + 1) % 2 == 0);
      na++;
    end else begin
      cea = 1'b0;
    end
    if (rst_b) begin
      nb = 0; ceb = 1'b0;
    end else if (en_b) begin
      ceb = ((nb + 1) % PDB == 0);
      nb++;
    end else begin
      ceb = 1'b0;
    end
  end

  always @(negedge clk) begin
    logic [5:0] o;
    longint xo, yo;
    if (chk_on) begin
      model(2, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0,
            na, cea, o, xo, yo);
      chk("a_flags", {ce_a, hs_a, vs_a, act_a, ls_a, fs_a}, o);
      chk("a_x", x_a, xo);
      chk("a_y", y_a, yo);
      model(PDB, 4, 1, 2, 1, 3, 1, 1, 1, 1'b1, 1'b0,
            nb, ceb, o, xo, yo);
      chk("b_flags", {ce_b, hs_b, vs_b, act_b, ls_b, fs_b}, o);
      chk("b_x", x_b, xo);
      chk("b_y", y_b, yo);
    end
  end

  initial begin
    int cnt, hlow, inact, lines;
    bit found;
    logic [7:0] hexp;

    repeat (2) @(negedge clk);
    chk_on = 1'b1;
    chk("t1_a_hsync", hs_a, 1);
    chk("t1_a_vsync", vs_a, 1);
    chk("t1_a_active", act_a, 0);
    chk("t1_a_xy", {x_a, y_a}, 0);
    chk("t1_a_ce", ce_a, 0);
    chk("t1_b_hsync", hs_b, 0);

    rst_a = 1'b0; en_a = 1'b1;
    @(negedge clk);
    chk("t2_no_first_ce", ce_a, 0);
    @(negedge clk);
    chk("t2_first_ce", ce_a, 1);
    chk("t2_first_fs", fs_a, 1);
    chk("t2_first_act", act_a, 1);
    chk("t2_first_xy", {x_a, y_a}, 0);

    cnt = 0; hlow = 0; inact = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      cnt++;
      if (ls_a) break;
      if (ce_a && !hs_a) hlow++;
      if (ce_a && !act_a) inact++;
      if (ce_a && !act_a && x_a != 0) chk("t3_x_blank", x_a, 0);
    end
    chk("t2_line_period", cnt, 1600);
    chk("t3_hsync_pixels", hlow, 96);
    chk("t3_blank_pixels", inact, 160);

    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      @(negedge clk);
      if (ce_a && x_a == 100) found = 1'b1;
    end
    chk("t5_reach_x100", found, 1);
    en_a = 1'b0;
    for (int i = 0; i < 37; i++) begin
      @(negedge clk);
      chk("t5_hold_ce", ce_a, 0);
      chk("t5_hold_x", x_a, 100);
    end
    en_a = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 4 && !found; i++) begin
      @(negedge clk);
      if (ce_a) found = 1'b1;
    end
    chk("t5_resume_ce", found, 1);
    chk("t5_resume_x", x_a, 101);

    rst_b = 1'b0; en_b = 1'b1;
    hexp = 8'b0110_0000;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("t6_ce_every_clk", ce_b, 1);
      chk("t6_hsync", hs_b, hexp[i]);
    end

    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge clk);
      if (fs_b) found = 1'b1;
    end
    chk("t6_frame_seen", found, 1);
    cnt = 0; lines = 1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      cnt++;
      if (fs_b) break;
      if (ls_b) lines++;
    end
    chk("t6_frame_period", cnt, 48);
    chk("t6_lines_per_frame", lines, 6);

    repeat (13) @(negedge clk);
    rst_b = 1'b1;
    @(negedge clk);
    chk("t6_rst_hsync", hs_b, 0);
    chk("t6_rst_vsync", vs_b, 1);
    chk("t6_rst_active", act_b, 0);
    chk("t6_rst_xy", {x_b, y_b}, 0);
    chk("t6_rst_ce", ce_b, 0);
    rst_b = 1'b0;

    repeat (4000) begin
      @(negedge clk);
      en_a  = ($urandom_range(0, 7) != 0);
      rst_a = ($urandom_range(0, 499) == 0);
      en_b  = ($urandom_range(0, 3) != 0);
      rst_b = ($urandom_range(0, 199) == 0);
    end
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
